// File: rtl/topk_select.sv
// topk_select: top-K selector for the PageRank ranking stage.
// A start request latches NUM_WORDS unsigned scores. A selection sort then runs
// TOP_K passes with one compare per cycle. The K largest scores are presented
// in descending order, together with their original indices.
// Optional feature macro: TOPK_MIN_SEL_EN. It adds the sel_min input, which is
// latched with start. When sel_min=1 the block selects the K smallest scores,
// in ascending order.
module topk_select #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WORDS  = 32,
    parameter int TOP_K      = 10,
    parameter int ID_WIDTH   = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
`ifdef TOPK_MIN_SEL_EN
    input  logic                             sel_min,
`endif
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  array_in,
    output logic                             busy,
    output logic                             done,
    output logic                             valid,
    output logic [DATA_WIDTH*TOP_K-1:0]      array_out,
    output logic [ID_WIDTH*TOP_K-1:0]        id_out
);

    // Index counters carry one spare bit, so p and head+2 never wrap past the last word.
    localparam int CW = ID_WIDTH + 1;
    // Address width of the score store.
    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] LAST_HEAD = CW'(TOP_K - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] TWO       = CW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    // Working copy of the scores and their original indices, reordered in place.
    logic [DATA_WIDTH-1:0] val [NUM_WORDS];
    logic [ID_WIDTH-1:0]   ids [NUM_WORDS];

    // head: slot being filled; best: current winner for that slot; p: compare pointer.
    logic [CW-1:0] head;
    logic [CW-1:0] best;
    logic [CW-1:0] p;

    // 1 = select smallest first. Hard-wired to 0 when the feature is not built.
    logic min_mode;

    logic [DATA_WIDTH-1:0] val_p;
    logic [DATA_WIDTH-1:0] val_best;
    logic [DATA_WIDTH-1:0] val_head;
    logic [ID_WIDTH-1:0]   id_best;
    logic [ID_WIDTH-1:0]   id_head;
    logic                  take;

    // Upper bit of best is never needed for addressing. It stays for symmetry with head and p.
    logic unused_best_msb;
    assign unused_best_msb = ^best[CW-1:AW];

`ifndef TOPK_MIN_SEL_EN
    assign min_mode = 1'b0;
`endif

    // Read ports for the current compare and the pending swap, plus the strict-compare decision.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        val_p    = val[p[AW-1:0]];
        val_best = val[best[AW-1:0]];
        val_head = val[head[AW-1:0]];
        id_best  = ids[best[AW-1:0]];
        id_head  = ids[head[AW-1:0]];
        // A strict compare keeps the lower position on equal scores.
        take     = min_mode ? (val_p < val_best) : (val_p > val_best);
    end

    // Sort controller: latch, scan and swap passes, then present the result on registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            array_out <= '0;
            id_out    <= '0;
            head      <= '0;
            best      <= '0;
            p         <= '0;
`ifdef TOPK_MIN_SEL_EN
            min_mode  <= 1'b0;
`endif
            // NOTE: the score store is cleared on reset on purpose. Nothing from an aborted sort may survive.
            for (int i = 0; i < NUM_WORDS; i++) begin
                val[i] <= '0;
                ids[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            val[i] <= array_in[i*DATA_WIDTH +: DATA_WIDTH];
                            ids[i] <= ID_WIDTH'(i);
                        end
`ifdef TOPK_MIN_SEL_EN
                        min_mode <= sel_min;
`endif
                        head  <= '0;
                        best  <= '0;
                        p     <= ONE;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                        state <= SCAN;
                    end
                end

                SCAN: begin
                    if (take) begin
                        best <= p;
                    end
                    if (p == LAST_IDX) begin
                        state <= SWAP;
                    end else begin
                        p <= p + ONE;
                    end
                end

                SWAP: begin
                    // When best == head both writes carry the same data, so the swap does nothing.
                    val[head[AW-1:0]] <= val_best;
                    val[best[AW-1:0]] <= val_head;
                    ids[head[AW-1:0]] <= id_best;
                    ids[best[AW-1:0]] <= id_head;
                    head <= head + ONE;
                    best <= head + ONE;
                    p    <= head + TWO;
                    if (head == LAST_HEAD) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (head + ONE == LAST_IDX) begin
                        // The last slot has nothing left to compare against, so skip the scan.
                        state <= SWAP;
                    end else begin
                        state <= SCAN;
                    end
                end

                DONE: begin
                    for (int j = 0; j < TOP_K; j++) begin
                        array_out[j*DATA_WIDTH +: DATA_WIDTH] <= val[j];
                        id_out[j*ID_WIDTH +: ID_WIDTH]        <= ids[j];
                    end
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_topk_select.sv
// tb_topk_select: self-checking bench for topk_select.
// It runs a default-size instance and a 4-word / top-4 instance side by side.
// Expected results come from an array-level selection-sort model of the ranking rule.
// The min-select scenario runs only when TOPK_MIN_SEL_EN is defined.
module tb_topk_select;

    localparam int DW     = 16;
    localparam int N      = 32;
    localparam int K      = 10;
    localparam int IDW    = 6;
    localparam int L      = K * N - K * (K - 1) / 2;
    localparam int N2     = 4;
    localparam int K2     = 4;
    localparam int IDW2   = 2;
    localparam int L2     = K2 * N2 - K2 * (K2 - 1) / 2;
    localparam int BUDGET = 2000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              start2;
`ifdef TOPK_MIN_SEL_EN
    logic              sel_min;
`endif
    logic [DW*N-1:0]   array_in;
    logic [DW*N2-1:0]  array_in2;
    logic              busy, done, valid;
    logic              busy2, done2, valid2;
    logic [DW*K-1:0]   array_out;
    logic [IDW*K-1:0]  id_out;
    logic [DW*K2-1:0]  array_out2;
    logic [IDW2*K2-1:0] id_out2;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    topk_select #(.DATA_WIDTH(DW), .NUM_WORDS(N), .TOP_K(K), .ID_WIDTH(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef TOPK_MIN_SEL_EN
        .sel_min   (sel_min),
`endif
        .array_in  (array_in),
        .busy      (busy),
        .done      (done),
        .valid     (valid),
        .array_out (array_out),
        .id_out    (id_out)
    );

    topk_select #(.DATA_WIDTH(DW), .NUM_WORDS(N2), .TOP_K(K2), .ID_WIDTH(IDW2)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
`ifdef TOPK_MIN_SEL_EN
        .sel_min   (1'b0),
`endif
        .array_in  (array_in2),
        .busy      (busy2),
        .done      (done2),
        .valid     (valid2),
        .array_out (array_out2),
        .id_out    (id_out2)
    );

    // Reference: repeatedly pick the strictly best remaining score (the first one found on ties)
    // and exchange it into the next result slot.
    function automatic void ref_topk(input int vals[$], input int k, input bit smin,
                                     output int ov[$], output int oid[$]);
        int v[$];
        int id[$];
        int b;
        int t;
        v  = vals;
        id = {};
        for (int i = 0; i < v.size(); i++) id.push_back(i);
        for (int h = 0; h < k; h++) begin
            b = h;
            for (int q = h + 1; q < v.size(); q++)
                if (smin ? (v[q] < v[b]) : (v[q] > v[b])) b = q;
            t = v[h];  v[h]  = v[b];  v[b]  = t;
            t = id[h]; id[h] = id[b]; id[b] = t;
        end
        ov  = {};
        oid = {};
        for (int j = 0; j < k; j++) begin
            ov.push_back(v[j]);
            oid.push_back(id[j]);
        end
    endfunction

    function automatic void expect_big(input logic [DW*N-1:0] data, input bit smin,
                                       output logic [DW*K-1:0] ea, output logic [IDW*K-1:0] ei);
        int q[$];
        int ov[$];
        int oid[$];
        q = {};
        for (int i = 0; i < N; i++) q.push_back(int'(data[i*DW +: DW]));
        ref_topk(q, K, smin, ov, oid);
        ea = '0;
        ei = '0;
        for (int j = 0; j < K; j++) begin
            ea[j*DW +: DW]   = ov[j][DW-1:0];
            ei[j*IDW +: IDW] = oid[j][IDW-1:0];
        end
    endfunction

    function automatic void expect_small(input logic [DW*N2-1:0] data,
                                         output logic [DW*K2-1:0] ea, output logic [IDW2*K2-1:0] ei);
        int q[$];
        int ov[$];
        int oid[$];
        q = {};
        for (int i = 0; i < N2; i++) q.push_back(int'(data[i*DW +: DW]));
        ref_topk(q, K2, 1'b0, ov, oid);
        ea = '0;
        ei = '0;
        for (int j = 0; j < K2; j++) begin
            ea[j*DW +: DW]     = ov[j][DW-1:0];
            ei[j*IDW2 +: IDW2] = oid[j][IDW2-1:0];
        end
    endfunction

    function automatic logic [DW*N-1:0] ramp(input int step);
        logic [DW*N-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(i * step);
        return d;
    endfunction

    // Waits (bounded) for done on the large instance; lat counts edges, with the accept edge as 1.
    task automatic wait_done(inout int lat, output bit to);
        to = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Issues one start. Returns in the done cycle (negedge), plus the flags seen right after acceptance.
    task automatic do_sort(input logic [DW*N-1:0] data, input bit hold, output int lat,
                           output bit to, output logic b_acc, output logic v_acc);
`ifdef TOPK_MIN_SEL_EN
        logic keep;
`endif
        @(negedge clk);
        array_in = data;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_acc = busy;
        v_acc = valid;
        if (!hold) start = 1'b0;
        array_in = ~data;
`ifdef TOPK_MIN_SEL_EN
        keep    = sel_min;
        sel_min = ~sel_min;
`endif
        lat = 1;
        wait_done(lat, to);
`ifdef TOPK_MIN_SEL_EN
        sel_min = keep;
`endif
    endtask

    task automatic do_sort2(input logic [DW*N2-1:0] data, output int lat, output bit to);
        @(negedge clk);
        array_in2 = data;
        start2    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2    = 1'b0;
        array_in2 = ~data;
        lat = 1;
        to  = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (done2 === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_run++;
        if ({busy, done, valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got=%b want=000", {busy, done, valid});
        end
        n_run++;
        if (array_out !== '0 || id_out !== '0) begin
            n_fail++; $display("FAIL reset_outputs got=%h/%h want=0/0", array_out, id_out);
        end
        n_run++;
        if ({busy2, done2, valid2} !== 3'b000 || array_out2 !== '0 || id_out2 !== '0) begin
            n_fail++; $display("FAIL reset_small got=%b %h %h want=000 0 0", {busy2, done2, valid2}, array_out2, id_out2);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({busy, done, valid} !== 3'b000) begin
            n_fail++; $display("FAIL idle_no_start got=%b want=000", {busy, done, valid});
        end
    endtask

    task automatic test_ascending;
        int lat; bit to; logic b_acc, v_acc;
        logic [DW*K-1:0] ea; logic [IDW*K-1:0] ei;
        logic [DW*K-1:0] held;
        for (int j = 0; j < K; j++) begin
            ea[j*DW +: DW]   = DW'(N - 1 - j);
            ei[j*IDW +: IDW] = IDW'(N - 1 - j);
        end
        do_sort(ramp(1), 1'b0, lat, to, b_acc, v_acc);
        n_run++;
        if (to) begin n_fail++; $display("FAIL asc_timeout got=no done want=done"); end
        n_run++;
        if (b_acc !== 1'b1 || v_acc !== 1'b0) begin
            n_fail++; $display("FAIL asc_accept got busy=%b valid=%b want busy=1 valid=0", b_acc, v_acc);
        end
        n_run++;
        if (lat != L + 1) begin n_fail++; $display("FAIL asc_latency got=%0d want=%0d", lat, L + 1); end
        n_run++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL asc_busy_in_done got=%b want=1", busy); end
        @(negedge clk);
        n_run++;
        if ({busy, done, valid} !== 3'b001) begin
            n_fail++; $display("FAIL asc_after_done got=%b want=001", {busy, done, valid});
        end
        n_run++;
        if (array_out !== ea) begin n_fail++; $display("FAIL asc_values got=%h want=%h", array_out, ea); end
        n_run++;
        if (id_out !== ei) begin n_fail++; $display("FAIL asc_ids got=%h want=%h", id_out, ei); end
        held = array_out;
        repeat (4) @(negedge clk);
        n_run++;
        if (array_out !== ea || valid !== 1'b1 || held !== ea) begin
            n_fail++; $display("FAIL asc_hold got=%h valid=%b want=%h valid=1", array_out, valid, ea);
        end
    endtask

    task automatic test_all_equal;
        int lat; bit to; logic b_acc, v_acc;
        logic [DW*N-1:0] d;
        logic [DW*K-1:0] ea; logic [IDW*K-1:0] ei;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 16'd7;
        for (int j = 0; j < K; j++) begin
            ea[j*DW +: DW]   = 16'd7;
            ei[j*IDW +: IDW] = IDW'(j);
        end
        do_sort(d, 1'b0, lat, to, b_acc, v_acc);
        @(negedge clk);
        n_run++;
        if (to || array_out !== ea) begin n_fail++; $display("FAIL equal_values got=%h want=%h", array_out, ea); end
        n_run++;
        if (id_out !== ei) begin n_fail++; $display("FAIL equal_ids got=%h want=%h", id_out, ei); end
    endtask

    task automatic test_start_held;
        int lat; bit to; logic b_acc, v_acc;
        logic [DW*K-1:0] ea1, ea3; logic [IDW*K-1:0] ei1, ei3;
        expect_big(ramp(1), 1'b0, ea1, ei1);
        expect_big(ramp(3), 1'b0, ea3, ei3);
        do_sort(ramp(1), 1'b1, lat, to, b_acc, v_acc);
        n_run++;
        if (to || lat != L + 1) begin n_fail++; $display("FAIL held_latency got=%0d want=%0d", lat, L + 1); end
        array_in = ramp(3);
        @(negedge clk);
        n_run++;
        if (busy !== 1'b0 || valid !== 1'b1 || array_out !== ea1) begin
            n_fail++; $display("FAIL held_single_sort got busy=%b valid=%b out=%h want busy=0 valid=1 out=%h", busy, valid, array_out, ea1);
        end
        @(negedge clk);
        n_run++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            n_fail++; $display("FAIL held_reaccept got busy=%b valid=%b want busy=1 valid=0", busy, valid);
        end
        start = 1'b0;
        lat = 1;
        wait_done(lat, to);
        @(negedge clk);
        n_run++;
        if (to || array_out[DW-1:0] !== 16'd93 || id_out[IDW-1:0] !== 6'd31) begin
            n_fail++; $display("FAIL held_second_slot0 got=%0d id=%0d want=93 id=31", array_out[DW-1:0], id_out[IDW-1:0]);
        end
        n_run++;
        if (array_out !== ea3 || id_out !== ei3) begin
            n_fail++; $display("FAIL held_second_all got=%h/%h want=%h/%h", array_out, id_out, ea3, ei3);
        end
    endtask

    task automatic test_ignore_busy;
        int lat; bit to;
        logic [DW*N-1:0] a;
        logic [DW*K-1:0] ea; logic [IDW*K-1:0] ei;
        for (int i = 0; i < N; i++) a[i*DW +: DW] = DW'($urandom);
        expect_big(a, 1'b0, ea, ei);
        @(negedge clk);
        array_in = a;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        repeat (20) begin @(negedge clk); lat++; end
        array_in = ramp(1);
        start    = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        wait_done(lat, to);
        n_run++;
        if (to || lat != L + 1) begin n_fail++; $display("FAIL busy_start_latency got=%0d want=%0d", lat, L + 1); end
        array_in = ramp(1);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_run++;
        if (array_out !== ea || id_out !== ei) begin
            n_fail++; $display("FAIL busy_start_result got=%h/%h want=%h/%h", array_out, id_out, ea, ei);
        end
        @(negedge clk);
        n_run++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL done_cycle_start got busy=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_sort;
        int lat; bit to; logic b_acc, v_acc;
        logic [DW*K-1:0] ea; logic [IDW*K-1:0] ei;
        expect_big(ramp(1), 1'b0, ea, ei);
        @(negedge clk);
        array_in = ramp(2);
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        n_run++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midsort_busy got=%b want=1", busy); end
        #2 rst = 1'b1;
        #1;
        n_run++;
        if ({busy, done, valid} !== 3'b000 || array_out !== '0 || id_out !== '0) begin
            n_fail++; $display("FAIL midsort_reset got=%b %h %h want=000 0 0", {busy, done, valid}, array_out, id_out);
        end
        @(negedge clk);
        rst = 1'b0;
        do_sort(ramp(1), 1'b0, lat, to, b_acc, v_acc);
        @(negedge clk);
        n_run++;
        if (to || lat != L + 1 || array_out !== ea || id_out !== ei) begin
            n_fail++; $display("FAIL after_reset_sort got lat=%0d %h/%h want lat=%0d %h/%h", lat, array_out, id_out, L + 1, ea, ei);
        end
    endtask

    task automatic test_small;
        int lat; bit to;
        logic [DW*N2-1:0] d;
        d = {16'd1, 16'd4, 16'd1, 16'd3};
        do_sort2(d, lat, to);
        n_run++;
        if (to || lat != L2 + 1) begin n_fail++; $display("FAIL small_latency got=%0d want=%0d", lat, L2 + 1); end
        @(negedge clk);
        n_run++;
        if (array_out2 !== {16'd1, 16'd1, 16'd3, 16'd4} || valid2 !== 1'b1) begin
            n_fail++; $display("FAIL small_values got=%h valid=%b want=%h valid=1", array_out2, valid2, {16'd1, 16'd1, 16'd3, 16'd4});
        end
        n_run++;
        if (id_out2 !== {2'd3, 2'd1, 2'd0, 2'd2}) begin
            n_fail++; $display("FAIL small_ids got=%b want=%b", id_out2, {2'd3, 2'd1, 2'd0, 2'd2});
        end
    endtask

    task automatic test_random;
        int lat; bit to; logic b_acc, v_acc;
        logic [DW*N-1:0] d;
        logic [DW*N2-1:0] d2;
        logic [DW*K-1:0] ea; logic [IDW*K-1:0] ei;
        logic [DW*K2-1:0] ea2; logic [IDW2*K2-1:0] ei2;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++)
                d[i*DW +: DW] = (r % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
            expect_big(d, 1'b0, ea, ei);
            do_sort(d, 1'b0, lat, to, b_acc, v_acc);
            @(negedge clk);
            n_run++;
            if (to || array_out !== ea || id_out !== ei) begin
                n_fail++; $display("FAIL random_%0d got=%h/%h want=%h/%h", r, array_out, id_out, ea, ei);
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N2; i++) d2[i*DW +: DW] = DW'($urandom_range(0, 5));
            expect_small(d2, ea2, ei2);
            do_sort2(d2, lat, to);
            @(negedge clk);
            n_run++;
            if (to || lat != L2 + 1 || array_out2 !== ea2 || id_out2 !== ei2) begin
                n_fail++; $display("FAIL small_random_%0d got=%h/%h want=%h/%h", r, array_out2, id_out2, ea2, ei2);
            end
        end
    endtask

`ifdef TOPK_MIN_SEL_EN
    task automatic test_min_sel;
        int lat; bit to; logic b_acc, v_acc;
        logic [DW*N-1:0] d;
        logic [DW*K-1:0] ea; logic [IDW*K-1:0] ei;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(N - 1 - i);
        for (int j = 0; j < K; j++) begin
            ea[j*DW +: DW]   = DW'(j);
            ei[j*IDW +: IDW] = IDW'(N - 1 - j);
        end
        sel_min = 1'b1;
        do_sort(d, 1'b0, lat, to, b_acc, v_acc);
        @(negedge clk);
        n_run++;
        if (to || lat != L + 1 || array_out !== ea || id_out !== ei) begin
            n_fail++; $display("FAIL min_sel got lat=%0d %h/%h want lat=%0d %h/%h", lat, array_out, id_out, L + 1, ea, ei);
        end
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom_range(0, 7));
        expect_big(d, 1'b1, ea, ei);
        do_sort(d, 1'b0, lat, to, b_acc, v_acc);
        @(negedge clk);
        n_run++;
        if (to || array_out !== ea || id_out !== ei) begin
            n_fail++; $display("FAIL min_sel_random got=%h/%h want=%h/%h", array_out, id_out, ea, ei);
        end
        for (int j = 0; j < K; j++) begin
            ea[j*DW +: DW]   = DW'(N - 1 - j);
            ei[j*IDW +: IDW] = IDW'(N - 1 - j);
        end
        sel_min = 1'b0;
        do_sort(ramp(1), 1'b0, lat, to, b_acc, v_acc);
        @(negedge clk);
        n_run++;
        if (to || array_out !== ea || id_out !== ei) begin
            n_fail++; $display("FAIL max_sel_again got=%h/%h want=%h/%h", array_out, id_out, ea, ei);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        array_in  = '0;
        array_in2 = '0;
`ifdef TOPK_MIN_SEL_EN
        sel_min   = 1'b0;
`endif
        test_reset();
        test_ascending();
        test_all_equal();
        test_start_held();
        test_ignore_busy();
        test_reset_mid_sort();
        test_small();
        test_random();
`ifdef TOPK_MIN_SEL_EN
        test_min_sel();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
